// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: TAP instruction codes and host scan FSM encoding.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package jtag_pkg;

    localparam int IR_BITS = 5;

    localparam logic [IR_BITS-1:0] IDCODE     = 5'h01;
    localparam logic [IR_BITS-1:0] BYPASS     = 5'h1F;
    localparam logic [IR_BITS-1:0] DTM_CSR    = 5'h10;
    localparam logic [IR_BITS-1:0] DMI_ACCESS = 5'h11;

    // EXIT1 is never occupied for a full period: the last SHIFT period drives
    // TMS=1, which carries the target through Exit1 on its way to Update.
    typedef enum logic [3:0] {
        ST_RESET_SEQ,
        ST_IDLE,
        ST_SEL_DR,
        ST_SEL_IR,
        ST_CAPTURE,
        ST_SHIFT,
        ST_EXIT1,
        ST_UPDATE,
        ST_RTI_RET
    } jtag_state_e;

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK divider: low half then high half of CLK_DIV Sys_clk cycles each, held low when idle.
// Latency: first rise_tick CLK_DIV cycles after run goes high.
// Backpressure: none; run gates the divider, dropping it parks TCK low.
module jtag_tck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic Sys_clk,
    input  logic TRST,
    input  logic run,
    output logic TCK,
    output logic fall_tick,
    output logic rise_tick
);

    localparam int            CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] div_cnt;
    logic          half_end;

    // A half-period ends on the last divider count; the strobe says which edge TCK takes next.
    assign half_end  = run && (div_cnt == CNT_LAST);
    assign rise_tick = half_end && !TCK;
    assign fall_tick = half_end && TCK;

    // Divider counter and TCK level; restarts from the start of a low half whenever run drops.
    always_ff @(posedge Sys_clk or negedge TRST) begin
        if (!TRST) begin
            div_cnt <= '0;
            TCK     <= 1'b0;
        end else if (!run) begin
            div_cnt <= '0;
            TCK     <= 1'b0;
        end else if (half_end) begin
            div_cnt <= '0;
            TCK     <= ~TCK;
        end else begin
            div_cnt <= div_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/jtag_host_driver.sv
// JTAG host scan engine: runs TAP reset, IR and DR scans, returns captured TDO bits.
// Latency: N+4 (DR) or N+5 (IR) TCK periods, rsp_valid one cycle after the last TCK falls.
// Backpressure: cmd_ready only in IDLE with no pending tap_reset_req; one command in flight.
module jtag_host_driver
    import jtag_pkg::*;
#(
    parameter int DATA_BITS = 41,
    parameter int LEN_BITS  = 6,
    parameter int CLK_DIV   = 2
) (
    input  logic                 Sys_clk,
    input  logic                 TRST,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_is_ir,
    input  logic [LEN_BITS-1:0]  cmd_len,
    input  logic [DATA_BITS-1:0] cmd_data,
    input  logic                 tap_reset_req,
    output logic                 rsp_valid,
    output logic [DATA_BITS-1:0] rsp_data,
    output logic                 busy,
    output logic                 TCK,
    output logic                 TMS,
    output logic                 TDI,
    input  logic                 TDO
);

    localparam logic [LEN_BITS-1:0] MAX_LEN = LEN_BITS'(DATA_BITS);

    jtag_state_e          state, state_nxt;
    logic                 tms_nxt, tdi_nxt, accept;
    logic [2:0]           rst_cnt;
    logic [LEN_BITS-1:0]  n_len, bit_idx, len_clamped;
    logic                 is_ir;
    logic [DATA_BITS-1:0] shift_dat;
    logic                 run, fall_tick, rise_tick;

    assign run         = (state != ST_IDLE);
    assign busy        = (state != ST_IDLE);
    assign cmd_ready   = (state == ST_IDLE) && !tap_reset_req;
    assign len_clamped = (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;

    jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
        .Sys_clk   (Sys_clk),
        .TRST      (TRST),
        .run       (run),
        .TCK       (TCK),
        .fall_tick (fall_tick),
        .rise_tick (rise_tick)
    );

    // Next state and next TMS/TDI; pins only move at a period boundary (fall_tick) or on entry from IDLE.
    always_comb begin
        state_nxt = state;
        tms_nxt   = TMS;
        tdi_nxt   = TDI;
        accept    = 1'b0;
        case (state)
            ST_RESET_SEQ: if (fall_tick) begin
                if (rst_cnt == 3'd5) begin
                    state_nxt = ST_IDLE;
                    tms_nxt   = 1'b0;
                end else begin
                    tms_nxt = (rst_cnt != 3'd4);
                end
            end
            ST_IDLE: begin
                if (tap_reset_req) begin
                    state_nxt = ST_RESET_SEQ;
                    tms_nxt   = 1'b1;
                end else if (cmd_valid) begin
                    accept = 1'b1;
                    if (len_clamped != '0) begin
                        state_nxt = ST_SEL_DR;
                        tms_nxt   = 1'b1;
                    end
                end
            end
            ST_SEL_DR: if (fall_tick) begin
                state_nxt = is_ir ? ST_SEL_IR : ST_CAPTURE;
                tms_nxt   = is_ir;
            end
            ST_SEL_IR: if (fall_tick) begin
                state_nxt = ST_CAPTURE;
                tms_nxt   = 1'b0;
            end
            ST_CAPTURE: if (fall_tick) begin
                state_nxt = ST_SHIFT;
                tms_nxt   = (n_len == LEN_BITS'(1));
                tdi_nxt   = shift_dat[0];
            end
            ST_SHIFT: if (fall_tick) begin
                if (bit_idx + LEN_BITS'(1) == n_len) begin
                    state_nxt = ST_UPDATE;
                    tms_nxt   = 1'b1;
                    tdi_nxt   = 1'b0;
                end else begin
                    tms_nxt = (bit_idx + LEN_BITS'(2) == n_len);
                    tdi_nxt = shift_dat[0];
                end
            end
            ST_UPDATE: if (fall_tick) begin
                state_nxt = ST_RTI_RET;
                tms_nxt   = 1'b0;
            end
            ST_RTI_RET: if (fall_tick) begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_RESET_SEQ;
                tms_nxt   = 1'b1;
            end
        endcase
    end

    // State, JTAG pins, command latch, shift datapath and response register.
    always_ff @(posedge Sys_clk or negedge TRST) begin
        if (!TRST) begin
            state     <= ST_RESET_SEQ;
            TMS       <= 1'b1;
            TDI       <= 1'b0;
            rst_cnt   <= '0;
            bit_idx   <= '0;
            n_len     <= '0;
            is_ir     <= 1'b0;
            shift_dat <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            state     <= state_nxt;
            TMS       <= tms_nxt;
            TDI       <= tdi_nxt;
            rsp_valid <= (accept && (len_clamped == '0)) || ((state == ST_RTI_RET) && fall_tick);
            if (accept) begin
                is_ir     <= cmd_is_ir;
                n_len     <= len_clamped;
                shift_dat <= cmd_data;
                bit_idx   <= '0;
                rsp_data  <= '0;
            end
            if ((state == ST_IDLE) && tap_reset_req) begin
                rst_cnt <= '0;
            end else if ((state == ST_RESET_SEQ) && fall_tick) begin
                rst_cnt <= rst_cnt + 3'd1;
            end
            // Bit 0 of shift_dat is always the next bit to present on TDI.
            if (fall_tick && ((state == ST_CAPTURE) || (state == ST_SHIFT))) begin
                shift_dat <= shift_dat >> 1;
            end
            if (fall_tick && (state == ST_SHIFT)) begin
                bit_idx <= bit_idx + LEN_BITS'(1);
            end
            if (rise_tick && (state == ST_SHIFT)) begin
                rsp_data[bit_idx] <= TDO;
            end
        end
    end

endmodule

// File: tb/tb_jtag_host_driver.sv
// Directed bench for jtag_host_driver with a behavioural target (bypass bit and 5-bit IR).
// Latency: n/a.
// Backpressure: waits on cmd_ready with a cycle budget.
module tb_jtag_host_driver;
    import jtag_pkg::*;

    logic        Sys_clk = 1'b0;
    logic        TRST = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_is_ir = 1'b0;
    logic [5:0]  cmd_len = '0;
    logic [40:0] cmd_data = '0;
    logic        tap_reset_req = 1'b0;
    logic        rsp_valid;
    logic [40:0] rsp_data;
    logic        busy, TCK, TMS, TDI, TDO;

    jtag_host_driver #(.DATA_BITS(41), .LEN_BITS(6), .CLK_DIV(2)) dut (
        .Sys_clk(Sys_clk), .TRST(TRST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_is_ir(cmd_is_ir), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .tap_reset_req(tap_reset_req), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .busy(busy), .TCK(TCK), .TMS(TMS), .TDI(TDI), .TDO(TDO)
    );

    always #5 Sys_clk = ~Sys_clk;

    int n_pass = 0;
    int n_total = 0;
    int tck_cnt = 0;
    int tck_base = 0;
    logic tms_log [256];

    // Target model: one-bit bypass register, or a 5-bit IR when ir_mode is set.
    logic       byp = 1'b0;
    logic [4:0] ir_sr = 5'h00;
    logic [4:0] ir_instr = 5'h00;
    logic       ir_mode = 1'b0;
    int         ir_len = 5;

    assign TDO = ir_mode ? ir_sr[0] : byp;

    always @(posedge TCK) begin
        int rel;
        rel = tck_cnt - tck_base;
        tms_log[rel[7:0]] = TMS;
        byp = TDI;
        if (ir_mode) begin
            if (rel == 2) ir_sr = IDCODE;
            else if (rel >= 3 && rel < 3 + ir_len) ir_sr = {TDI, ir_sr[4:1]};
            else if (rel == 3 + ir_len) ir_instr = ir_sr;
        end
        tck_cnt++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic exp_tms(input logic is_ir, input int n, input int p);
        int pre;
        pre = is_ir ? 3 : 2;
        if (p < pre) return (p == 0) || (is_ir && p == 1);
        if (p < pre + n) return (p == pre + n - 1);
        return (p == pre + n);
    endfunction

    function automatic logic reset_tms_ok(input int tcks);
        logic ok;
        ok = 1'b1;
        for (int p = 0; p < tcks && p < 256; p++)
            if (tms_log[p] !== (p < 5)) ok = 1'b0;
        return ok;
    endfunction

    task automatic run_cmd(input logic is_ir, input logic [5:0] len, input logic [40:0] data,
                           output logic got_vld, output logic [40:0] got_rsp,
                           output int got_tcks, output int got_lat, output logic tms_ok);
        int budget;
        int n;
        got_vld = 1'b0; got_rsp = '0; got_lat = -1; tms_ok = 1'b1; budget = 0;
        @(negedge Sys_clk);
        while (!cmd_ready && budget < 500) begin @(negedge Sys_clk); budget++; end
        tck_base = tck_cnt; ir_mode = is_ir; ir_len = int'(len);
        cmd_is_ir = is_ir; cmd_len = len; cmd_data = data; cmd_valid = 1'b1;
        @(negedge Sys_clk);
        cmd_valid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (rsp_valid) begin got_vld = 1'b1; got_rsp = rsp_data; got_lat = c; break; end
            @(negedge Sys_clk);
        end
        got_tcks = tck_cnt - tck_base;
        n = (len > 6'd41) ? 41 : int'(len);
        for (int p = 0; p < got_tcks && p < 256; p++)
            if (tms_log[p] !== exp_tms(is_ir, n, p)) tms_ok = 1'b0;
    endtask

    typedef struct {
        logic        is_ir;
        logic [5:0]  len;
        logic [40:0] data;
        logic [40:0] exp_rsp;
        int          exp_tcks;
        logic [4:0]  exp_instr;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic        vld, tms_ok, saw_vld;
        logic [40:0] rsp;
        int          tcks, lat, cyc;

        vecs[0] = '{1'b1, 6'd5,  41'(DMI_ACCESS), 41'h01, 10, DMI_ACCESS};
        vecs[1] = '{1'b0, 6'd8,  41'hA5,          41'h4A, 12, 5'h00};
        vecs[2] = '{1'b0, 6'd0,  41'h1234,        41'h00, 0,  5'h00};
        vecs[3] = '{1'b0, 6'd63, 41'h0ABCDEF0123, 41'h1579BDE0246, 45, 5'h00};
        vecs[4] = '{1'b1, 6'd5,  41'(DTM_CSR),    41'h01, 10, DTM_CSR};
        vecs[5] = '{1'b0, 6'd1,  41'h1,           41'h0,  5,  5'h00};
        vecs[6] = '{1'b0, 6'd41, 41'h1FFFFFFFFFF, 41'h1FFFFFFFFFE, 45, 5'h00};
        vecs[7] = '{1'b1, 6'd5,  41'(BYPASS),     41'h01, 10, BYPASS};

        // Reset values while TRST is held low.
        #12;
        check("rst_pins {TCK,TMS,TDI,rdy,busy,vld}", {58'd0, TCK, TMS, TDI, cmd_ready, busy, rsp_valid}, 64'b010010);
        check("rst_rsp_data", 64'(rsp_data), 64'd0);

        // Release: 6 TCKs of 4 Sys_clk each, TMS 1,1,1,1,1,0, then cmd_ready.
        @(negedge Sys_clk);
        tck_base = tck_cnt;
        TRST = 1'b1;
        cyc = 0;
        while (!cmd_ready && cyc < 200) begin @(negedge Sys_clk); cyc++; end
        check("rst_seq_cycles", 64'(cyc), 64'd24);
        check("rst_seq_tcks", 64'(tck_cnt - tck_base), 64'd6);
        check("rst_seq_tms", 64'(reset_tms_ok(tck_cnt - tck_base)), 64'd1);
        check("rst_seq_busy", 64'(busy), 64'd0);

        for (int i = 0; i < 8; i++) begin
            run_cmd(vecs[i].is_ir, vecs[i].len, vecs[i].data, vld, rsp, tcks, lat, tms_ok);
            check($sformatf("v%0d_rsp_valid", i), 64'(vld), 64'd1);
            check($sformatf("v%0d_rsp_data", i), 64'(rsp), 64'(vecs[i].exp_rsp));
            check($sformatf("v%0d_tck_count", i), 64'(tcks), 64'(vecs[i].exp_tcks));
            check($sformatf("v%0d_tms_seq", i), 64'(tms_ok), 64'd1);
            if (vecs[i].is_ir)
                check($sformatf("v%0d_target_instr", i), 64'(ir_instr), 64'(vecs[i].exp_instr));
        end

        // Zero length: response in the cycle right after acceptance, one-cycle pulse, data held.
        run_cmd(1'b0, 6'd0, 41'h3, vld, rsp, tcks, lat, tms_ok);
        check("len0_latency", 64'(lat), 64'd0);
        check("len0_tcks", 64'(tcks), 64'd0);
        @(negedge Sys_clk);
        check("len0_pulse_width", 64'(rsp_valid), 64'd0);
        run_cmd(1'b0, 6'd4, 41'h6, vld, rsp, tcks, lat, tms_ok);
        @(negedge Sys_clk);
        @(negedge Sys_clk);
        check("rsp_data_hold", 64'(rsp_data), 64'hC);

        // TRST during the third SHIFT period of a DR scan.
        cyc = 0;
        while (!cmd_ready && cyc < 200) begin @(negedge Sys_clk); cyc++; end
        tck_base = tck_cnt; ir_mode = 1'b0;
        cmd_is_ir = 1'b0; cmd_len = 6'd8; cmd_data = 41'hA5; cmd_valid = 1'b1;
        @(negedge Sys_clk);
        cmd_valid = 1'b0;
        cyc = 0;
        while ((tck_cnt - tck_base) < 5 && cyc < 200) begin @(negedge Sys_clk); cyc++; end
        check("abort_reached_shift3", 64'(TCK && busy), 64'd1);
        TRST = 1'b0;
        #1;
        check("abort_pins {TCK,TMS,TDI,rdy,busy,vld}", {58'd0, TCK, TMS, TDI, cmd_ready, busy, rsp_valid}, 64'b010010);
        check("abort_rsp_data", 64'(rsp_data), 64'd0);
        @(negedge Sys_clk);
        @(negedge Sys_clk);
        tck_base = tck_cnt;
        TRST = 1'b1;
        cyc = 0; saw_vld = 1'b0;
        while (!cmd_ready && cyc < 200) begin
            @(negedge Sys_clk); cyc++;
            if (rsp_valid) saw_vld = 1'b1;
        end
        check("abort_no_rsp_valid", 64'(saw_vld), 64'd0);
        check("abort_reseq_tcks", 64'(tck_cnt - tck_base), 64'd6);
        check("abort_reseq_tms", 64'(reset_tms_ok(tck_cnt - tck_base)), 64'd1);

        // tap_reset_req together with cmd_valid: reset sequence first, command after it.
        @(negedge Sys_clk);
        tck_base = tck_cnt; ir_mode = 1'b0;
        tap_reset_req = 1'b1;
        cmd_is_ir = 1'b0; cmd_len = 6'd8; cmd_data = 41'hA5; cmd_valid = 1'b1;
        #1;
        check("req_blocks_ready", 64'(cmd_ready), 64'd0);
        @(negedge Sys_clk);
        tap_reset_req = 1'b0;
        check("req_busy {busy,rdy}", {62'd0, busy, cmd_ready}, 64'b10);
        cyc = 0;
        while (!cmd_ready && cyc < 200) begin @(negedge Sys_clk); cyc++; end
        check("req_reseq_tcks", 64'(tck_cnt - tck_base), 64'd6);
        check("req_reseq_tms", 64'(reset_tms_ok(tck_cnt - tck_base)), 64'd1);
        tck_base = tck_cnt;
        @(negedge Sys_clk);
        cmd_valid = 1'b0;
        vld = 1'b0; rsp = '0;
        for (int c = 0; c < 400; c++) begin
            if (rsp_valid) begin vld = 1'b1; rsp = rsp_data; break; end
            @(negedge Sys_clk);
        end
        check("req_cmd_rsp_valid", 64'(vld), 64'd1);
        check("req_cmd_rsp_data", 64'(rsp), 64'h4A);
        check("req_cmd_tcks", 64'(tck_cnt - tck_base), 64'd12);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
